// File: rtl/dsp_mac_pkg.sv
// Shared constants and the overflow-aware adder for the multi-channel MAC.
// Build option: define DSP_MAC_SAT_EN to clamp overflowing sums instead of wrapping.
package dsp_mac_pkg;

  localparam logic [1:0] ACC_LOAD = 2'd0;
  localparam logic [1:0] ACC_ADD  = 2'd1;
  localparam logic [1:0] ACC_SUB  = 2'd2;
  localparam logic [1:0] ACC_C    = 2'd3;

  localparam int OP_PREADD_EN  = 0;
  localparam int OP_PREADD_SUB = 1;
  localparam int OP_MODE_LO    = 2;
  localparam int OP_MODE_HI    = 3;

  localparam int SAT_MAX_W = 128;
  localparam int SAT_IW    = $clog2(SAT_MAX_W);

  // Adds a + (sub ? -b : b) + cin at width w (w < SAT_MAX_W); returns {ovf, result}.
  function automatic logic [SAT_MAX_W:0] sat_add(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input logic                 cin,
    input logic                 sub,
    input int                   w
  );
    logic [SAT_MAX_W-1:0] mask;
    logic [SAT_MAX_W-1:0] bn;
    logic [SAT_MAX_W-1:0] r;
    logic                 ovf;
    mask = (w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
    bn   = (sub ? (~b + SAT_MAX_W'(1)) : b) & mask;
    r    = (a + bn + SAT_MAX_W'(cin)) & mask;
    ovf  = (a[SAT_IW'(w - 1)] == bn[SAT_IW'(w - 1)]) && (r[SAT_IW'(w - 1)] != a[SAT_IW'(w - 1)]);
`ifdef DSP_MAC_SAT_EN
    // On overflow both addends share the sign of the true result.
    if (ovf) begin
      r = a[SAT_IW'(w - 1)] ? (SAT_MAX_W'(1) << (w - 1)) : (mask >> 1);
    end
`endif
    return {ovf, r};
  endfunction

endpackage

// File: rtl/dsp_mac_acc_bank.sv
// Per-channel accumulator register file: combinational read, synchronous write and clear.
// Out-of-range addresses read as zero with rhit low and never write.
module dsp_mac_acc_bank #(
  parameter int CHANNELS  = 4,
  parameter int ACC_WIDTH = 48,
  parameter int CH_W      = 2
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 we,
  input  logic [CH_W-1:0]      waddr,
  input  logic [ACC_WIDTH-1:0] wdata,
  input  logic [CH_W-1:0]      raddr,
  output logic [ACC_WIDTH-1:0] rdata,
  output logic                 rhit
);

  logic [ACC_WIDTH-1:0] acc_q [CHANNELS];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [ACC_WIDTH-1:0] acc_reg;
      always_ff @(posedge clk) begin
        if (srst) begin
          acc_reg <= '0;
        end else if (we && (waddr == CH_W'(gi))) begin
          acc_reg <= wdata;
        end
      end
      assign acc_q[gi] = acc_reg;
    end
  endgenerate

  always_comb begin
    rdata = '0;
    rhit  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (raddr == CH_W'(i)) begin
        rdata = acc_q[i];
        rhit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsp_mac_multich.sv
// Three-stage signed pre-add/multiply/accumulate with per-channel accumulators and
// valid/ready back-pressure. Define DSP_MAC_SAT_EN for saturating results.
module dsp_mac_multich
  import dsp_mac_pkg::*;
#(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 48,
  parameter int CHANNELS  = 4,
  localparam int CH_W     = $clog2(CHANNELS)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  input  logic [CH_W-1:0]             CH_IN,
  input  logic signed [A_WIDTH-1:0]   A,
  input  logic signed [B_WIDTH-1:0]   B,
  input  logic signed [B_WIDTH-1:0]   D,
  input  logic [ACC_WIDTH-1:0]        C,
  input  logic [3:0]                  OPMODE_IN,
  input  logic                        CARRYIN,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic [CH_W-1:0]             CH_OUT,
  output logic [ACC_WIDTH-1:0]        P,
  output logic                        OVF
);

  localparam int PW = A_WIDTH + B_WIDTH + 1;

  logic adv;
  assign adv      = !OUT_VALID || OUT_READY;
  assign IN_READY = adv && !RST;

  logic signed [A_WIDTH-1:0] a1_reg;
  logic signed [B_WIDTH-1:0] b1_reg, d1_reg;
  logic [ACC_WIDTH-1:0]      c1_reg;
  logic [CH_W-1:0]           ch1_reg;
  logic [3:0]                op1_reg;
  logic                      cin1_reg, v1_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      a1_reg <= '0; b1_reg <= '0; d1_reg <= '0; c1_reg <= '0;
      ch1_reg <= '0; op1_reg <= '0; cin1_reg <= 1'b0; v1_reg <= 1'b0;
    end else if (adv) begin
      a1_reg   <= A;
      b1_reg   <= B;
      d1_reg   <= D;
      c1_reg   <= C;
      ch1_reg  <= CH_IN;
      op1_reg  <= OPMODE_IN;
      cin1_reg <= CARRYIN;
      v1_reg   <= IN_VALID && IN_READY;
    end
  end

  // Pre-adder is one bit wider than its operands so D+/-B never wraps.
  logic signed [B_WIDTH:0]    b_ext, d_ext, pre_next;
  logic signed [PW-1:0]       prod_next;
  logic [ACC_WIDTH-1:0]       m_next;

  always_comb begin
    b_ext = {b1_reg[B_WIDTH-1], b1_reg};
    d_ext = {d1_reg[B_WIDTH-1], d1_reg};
    if (op1_reg[OP_PREADD_EN]) begin
      pre_next = op1_reg[OP_PREADD_SUB] ? (d_ext - b_ext) : (d_ext + b_ext);
    end else begin
      pre_next = b_ext;
    end
    prod_next = PW'(a1_reg) * PW'(pre_next);
    m_next    = ACC_WIDTH'(prod_next);
  end

  logic [ACC_WIDTH-1:0] m2_reg, c2_reg;
  logic [CH_W-1:0]      ch2_reg;
  logic [1:0]           mode2_reg;
  logic                 cin2_reg, v2_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      m2_reg <= '0; c2_reg <= '0; ch2_reg <= '0;
      mode2_reg <= '0; cin2_reg <= 1'b0; v2_reg <= 1'b0;
    end else if (adv) begin
      m2_reg    <= m_next;
      c2_reg    <= c1_reg;
      ch2_reg   <= ch1_reg;
      mode2_reg <= op1_reg[OP_MODE_HI:OP_MODE_LO];
      cin2_reg  <= cin1_reg;
      v2_reg    <= v1_reg;
    end
  end

  logic [ACC_WIDTH-1:0] acc_rd, addend_a, sum;
  logic                 acc_hit, sub, ovf_sum, acc_we;
  logic [SAT_MAX_W:0]   sa_res;
  logic                 sat_unused;

  always_comb begin
    addend_a = '0;
    unique case (mode2_reg)
      ACC_LOAD:         addend_a = '0;
      ACC_ADD, ACC_SUB: addend_a = acc_rd;
      default:          addend_a = c2_reg;
    endcase
    sub     = (mode2_reg == ACC_SUB);
    sa_res  = sat_add(SAT_MAX_W'(addend_a), SAT_MAX_W'(m2_reg), cin2_reg, sub, ACC_WIDTH);
    sum     = sa_res[ACC_WIDTH-1:0];
    ovf_sum = sa_res[SAT_MAX_W];
  end

  assign sat_unused = ^sa_res[SAT_MAX_W-1:ACC_WIDTH];
  assign acc_we     = adv && v2_reg && acc_hit;

  dsp_mac_acc_bank #(
    .CHANNELS  (CHANNELS),
    .ACC_WIDTH (ACC_WIDTH),
    .CH_W      (CH_W)
  ) u_acc_bank (
    .clk   (CLK),
    .srst  (RST),
    .we    (acc_we),
    .waddr (ch2_reg),
    .wdata (sum),
    .raddr (ch2_reg),
    .rdata (acc_rd),
    .rhit  (acc_hit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      P         <= '0;
      OVF       <= 1'b0;
      CH_OUT    <= '0;
    end else if (adv) begin
      OUT_VALID <= v2_reg;
      if (v2_reg) begin
        P      <= sum;
        OVF    <= ovf_sum && acc_hit;
        CH_OUT <= ch2_reg;
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_multich.sv
// Self-checking bench for dsp_mac_multich: directed steps plus randomized beats
// scored against an arithmetic per-channel accumulator model.
module tb_dsp_mac_multich;

  localparam int AW  = 18;
  localparam int BW  = 18;
  localparam int CW  = 48;
  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam longint MAXV = (64'sd1 <<< 47) - 64'sd1;
  localparam longint MINV = -(64'sd1 <<< 47);
  localparam longint MODW = (64'sd1 <<< 48);

  logic                 CLK = 1'b0;
  logic                 RST, IN_VALID, IN_READY, CARRYIN, OUT_VALID, OUT_READY, OVF;
  logic [CHW-1:0]       CH_IN, CH_OUT;
  logic signed [AW-1:0] A;
  logic signed [BW-1:0] B, D;
  logic [CW-1:0]        C, P;
  logic [3:0]           OPMODE_IN;

  always #5 CLK = ~CLK;

  dsp_mac_multich dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .CH_IN(CH_IN),
    .A(A), .B(B), .D(D), .C(C), .OPMODE_IN(OPMODE_IN), .CARRYIN(CARRYIN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .CH_OUT(CH_OUT), .P(P), .OVF(OVF)
  );

  typedef struct { int ch; longint p; bit ovf; } exp_t;
  exp_t   q[$];
  longint acc_m[NCH];
  int     checks = 0;
  int     failures = 0;
  int     outs = 0;
  bit     rand_ready = 1'b0;
  bit     accepted, obs_valid, stalled;
  logic signed [63:0] stall_p, last_p;
  logic               last_ovf;

  function automatic logic signed [63:0] sx(input logic [CW-1:0] v);
    return 64'($signed(v));
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: accumulate with plain integer arithmetic, then wrap or clamp to 48 bits.
  task automatic model_accept();
    longint a, b, d, c, pre, m, base, tot, res;
    int     ch;
    bit     ovf;
    exp_t   e;
    ch = int'(CH_IN);
    a = longint'(A); b = longint'(B); d = longint'(D); c = longint'($signed(C));
    pre = OPMODE_IN[0] ? (OPMODE_IN[1] ? d - b : d + b) : b;
    m = a * pre;
    case (OPMODE_IN[3:2])
      2'd0:    base = 0;
      2'd3:    base = c;
      default: base = acc_m[ch];
    endcase
    tot = base + ((OPMODE_IN[3:2] == 2'd2) ? -m : m) + longint'(CARRYIN);
    ovf = (tot > MAXV) || (tot < MINV);
`ifdef DSP_MAC_SAT_EN
    res = ovf ? ((tot > 0) ? MAXV : MINV) : tot;
`else
    res = tot;
    if (res > MAXV) res = res - MODW;
    if (res < MINV) res = res + MODW;
`endif
    acc_m[ch] = res;
    e.ch = ch; e.p = res; e.ovf = ovf;
    q.push_back(e);
  endtask

  task automatic tick();
    bit   inf, outf;
    exp_t e;
    @(negedge CLK);
    if (stalled) begin
      chk("stall_valid", 64'(OUT_VALID), 64'sd1);
      chk("stall_p", sx(P), stall_p);
    end
    inf       = IN_VALID && IN_READY;
    outf      = OUT_VALID && OUT_READY;
    obs_valid = OUT_VALID;
    if (outf) begin
      outs++;
      chk("out_expected", 64'(q.size() > 0), 64'sd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_ch", 64'(CH_OUT), 64'(e.ch));
        chk("out_p", sx(P), e.p);
        chk("out_ovf", 64'(OVF), 64'(e.ovf));
      end
      last_p   = sx(P);
      last_ovf = OVF;
      $display("out ch=%0d P=%0d OVF=%0b", CH_OUT, sx(P), OVF);
    end
    if (inf) model_accept();
    accepted = inf;
    stalled  = OUT_VALID && !OUT_READY;
    stall_p  = sx(P);
    @(posedge CLK);
    #1;
    OUT_READY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic send(input int ch, input longint a, input longint b, input longint d,
                      input longint c, input logic [3:0] op, input bit cin);
    CH_IN = CHW'(ch); A = AW'(a); B = BW'(b); D = BW'(d); C = CW'(c);
    OPMODE_IN = op; CARRYIN = cin; IN_VALID = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (accepted) break;
    end
    if (!accepted) chk("accept_timeout", 64'(accepted), 64'sd1);
  endtask

  task automatic drain();
    IN_VALID = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk("drain_empty", 64'(q.size()), 64'sd0);
  endtask

  initial begin
    int outs0;
    logic [3:0] op;
    for (int i = 0; i < NCH; i++) acc_m[i] = 0;
    stalled = 1'b0; last_p = '0; last_ovf = 1'b0;
    RST = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b1;
    CH_IN = '0; A = '0; B = '0; D = '0; C = '0; OPMODE_IN = '0; CARRYIN = 1'b0;

    // Reset with an offered beat: nothing may be accepted.
    repeat (2) begin
      tick();
      chk("rst_in_ready", 64'(IN_READY), 64'sd0);
      chk("rst_out_valid", 64'(OUT_VALID), 64'sd0);
      chk("rst_p", sx(P), 64'sd0);
    end
    RST = 1'b0; IN_VALID = 1'b0;
    #1;
    chk("ready_after_rst", 64'(IN_READY), 64'sd1);

    // Load and pipeline latency: result appears on the second edge after the accept edge.
    send(0, 3, 4, 0, 0, 4'b0000, 1'b0);
    IN_VALID = 1'b0;
    tick(); tick();
    chk("lat_early", 64'(obs_valid), 64'sd0);
    tick();
    chk("lat_edge", 64'(obs_valid), 64'sd1);
    chk("load_p", last_p, 64'sd12);
    chk("load_ovf", 64'(last_ovf), 64'sd0);
    drain();

    // Interleaved ch0/ch1 accumulation, then back-to-back same-channel beats on ch2.
    for (int r = 0; r < 4; r++) begin
      op = (r == 0) ? 4'b0000 : 4'b0100;
      send(0, 2, 5, 0, 0, op, 1'b0);
      send(1, 2, 5, 0, 0, op, 1'b0);
    end
    drain();
    chk("interleave_last", last_p, 64'sd40);
    send(2, 2, 5, 0, 0, 4'b0000, 1'b0);
    send(2, 2, 5, 0, 0, 4'b0100, 1'b0);
    send(2, 2, 5, 0, 0, 4'b0100, 1'b0);
    drain();
    chk("same_ch_last", last_p, 64'sd30);

    // Pre-adder subtract, then accumulate on top.
    send(3, -2, 3, 10, 0, 4'b0011, 1'b0);
    drain();
    chk("preadd_sub", last_p, -64'sd14);
    send(3, -2, 3, 10, 0, 4'b0111, 1'b0);
    drain();
    chk("preadd_acc", last_p, -64'sd28);

    // Random beats under random back-pressure.
    rand_ready = 1'b1;
    outs0 = outs;
    for (int n = 0; n < 8; n++) begin
      send(int'($urandom_range(0, NCH - 1)),
           longint'($signed(AW'($urandom))), longint'($signed(BW'($urandom))),
           longint'($signed(BW'($urandom))),
           longint'($signed(CW'({$urandom, $urandom}))),
           4'($urandom), 1'($urandom));
    end
    drain();
    rand_ready = 1'b0;
    chk("bp_count", 64'(outs - outs0), 64'sd8);
    // Read every accumulator back through an add of zero.
    for (int ch = 0; ch < NCH; ch++) send(ch, 0, 0, 0, 0, 4'b0100, 1'b0);
    drain();

    // Overflow at the positive boundary.
    send(0, 0, 0, 0, MAXV, 4'b1100, 1'b0);
    drain();
    chk("ovf_load", last_p, MAXV);
    send(0, 1, 1, 0, 0, 4'b0100, 1'b0);
    drain();
`ifdef DSP_MAC_SAT_EN
    chk("ovf_p", last_p, MAXV);
`else
    chk("ovf_p", last_p, MINV);
`endif
    chk("ovf_flag", 64'(last_ovf), 64'sd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
